// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: data/operation types, requester index
// and the response-buffer state encoding.
package alu_arbiter_pkg;

    localparam int MAX_REQ = 4;
    localparam int DATA_W  = 32;

    typedef logic [DATA_W-1:0] Data;
    typedef logic [DATA_W-1:0] DataReg;
    typedef logic              Bool;
    typedef logic [1:0]        ReqIdx;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLT  = 4'd5,
        SLTU = 4'd6,
        SL   = 4'd7,
        SR   = 4'd8
    } ALUOp;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } BufState;

endpackage

// File: rtl/alu_arb_rr.sv
// Round-robin picker: grants the first eligible requester after last_grant_i,
// wrapping modulo NUM_REQ. Purely combinational.
module alu_arb_rr
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  ReqIdx              last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output ReqIdx              grant_idx_o
);

    logic found;

    // Scan offsets 1..NUM_REQ from the last winner; first eligible hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = last_grant_i;
        found       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && eligible_i[i] &&
                    (i == (int'(last_grant_i) + k) % NUM_REQ)) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = ReqIdx'(i);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration and a one-entry response buffer per requester.
// Optional build macro: ALU_ARB_STATS_EN adds grant_count_o / stall_count_o.
//
// Response buffer FSM (one per requester):
//   state     | meaning
//   BUF_EMPTY | no result held; requester may be granted
//   BUF_FULL  | result held in data_q; granted again only if drained same cycle
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  ALUOp [NUM_REQ-1:0]   req_op_i,
    input  Data  [NUM_REQ-1:0]   req_a_i,
    input  Data  [NUM_REQ-1:0]   req_b_i,
    input  Bool  [NUM_REQ-1:0]   req_mod_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   resp_valid_o,
    output Data  [NUM_REQ-1:0]   resp_data_o,
    input  logic [NUM_REQ-1:0]   resp_ready_i,
    output ALUOp                 alu_op_o,
    output Data                  alu_a_o,
    output Data                  alu_b_o,
    output Bool                  alu_mod_o,
    input  Data                  alu_res_i
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0] grant_count_o,
    output logic [31:0]              stall_count_o
`endif
);

    BufState [NUM_REQ-1:0] state_q, state_d;
    DataReg  [NUM_REQ-1:0] data_q, data_d;
    ReqIdx                 last_grant_q, last_grant_d;
    logic    [NUM_REQ-1:0] eligible;
    logic    [NUM_REQ-1:0] grant;
    ReqIdx                 grant_idx;

    // A requester may win only if its buffer is free or being drained this cycle.
    always_comb begin
        resp_valid_o = '0;
        eligible     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_o[i] = (state_q[i] == BUF_FULL);
            eligible[i]     = !reset_i && req_valid_i[i] &&
                              ((state_q[i] == BUF_EMPTY) || resp_ready_i[i]);
        end
    end

    alu_arb_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .eligible_i   (eligible),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign req_ready_o = grant;
    assign resp_data_o = data_q;

    // Steer the winner's operands to the shared ALU; idle as ADD 0,0.
    always_comb begin
        alu_op_o  = ADD;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_mod_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_op_o  = req_op_i[i];
                alu_a_o   = req_a_i[i];
                alu_b_o   = req_b_i[i];
                alu_mod_o = req_mod_i[i];
            end
        end
    end

    // Buffer next-state: a grant always (re)loads; a drain without grant empties.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_grant_d = (|grant) ? grant_idx : last_grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            case (state_q[i])
                BUF_EMPTY: begin
                    if (grant[i]) begin
                        state_d[i] = BUF_FULL;
                        data_d[i]  = alu_res_i;
                    end
                end
                BUF_FULL: begin
                    if (grant[i]) begin
                        data_d[i] = alu_res_i;
                    end else if (resp_ready_i[i]) begin
                        state_d[i] = BUF_EMPTY;
                    end
                end
                default: state_d[i] = BUF_EMPTY;
            endcase
        end
    end

    // State registers; reset drops any in-flight result and points RR at req 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= BUF_EMPTY;
            end
            data_q       <= '0;
            last_grant_q <= ReqIdx'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q;
    logic [31:0]              stall_cnt_q;
    logic                     stall_any;

    // A stall is a valid request blocked by its own undrained response.
    always_comb begin
        stall_any = |(req_valid_i & resp_valid_o & ~resp_ready_i);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (stall_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign grant_count_o = grant_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, a round-robin
// reference model with per-requester result queues, plus directed checks.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NUM_REQ = 2;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [NUM_REQ-1:0]   req_valid;
    ALUOp [NUM_REQ-1:0]   req_op;
    Data  [NUM_REQ-1:0]   req_a;
    Data  [NUM_REQ-1:0]   req_b;
    Bool  [NUM_REQ-1:0]   req_mod;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   resp_valid;
    Data  [NUM_REQ-1:0]   resp_data;
    logic [NUM_REQ-1:0]   resp_ready;
    ALUOp                 alu_op;
    Data                  alu_a;
    Data                  alu_b;
    Bool                  alu_mod;
    Data                  alu_res;
`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_count;
    logic [31:0]              stall_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_mod_i    (req_mod),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .resp_ready_i (resp_ready),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_mod_o    (alu_mod),
        .alu_res_i    (alu_res)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_count_o (grant_count),
        .stall_count_o (stall_count)
`endif
    );

    function automatic Data alu_fn(ALUOp op, Data a, Data b, Bool m);
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            AND:  return a & b;
            OR:   return a | b;
            XOR:  return a ^ b;
            SLT:  return {31'd0, ($signed(a) < $signed(b))};
            SLTU: return {31'd0, (a < b)};
            SL:   return a << b[4:0];
            SR:   return m ? Data'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            default: return '0;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b, alu_mod);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [NUM_REQ-1:0] m_full = '0;
    int                 m_last = NUM_REQ - 1;
    Data                sbq[NUM_REQ][$];

    always @(negedge clk_i) begin
        logic [NUM_REQ-1:0] exp_g;
        int                 gidx;
        bit                 found;
        if (mon_en) begin
            exp_g = '0;
            gidx  = m_last;
            found = 1'b0;
            if (!reset_i) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int j;
                    j = (m_last + k) % NUM_REQ;
                    if (!found && req_valid[j] && (!m_full[j] || resp_ready[j])) begin
                        exp_g[j] = 1'b1;
                        gidx     = j;
                        found    = 1'b1;
                    end
                end
            end
            check_val("req_ready", 32'(req_ready), 32'(exp_g));
            check_val("resp_valid", 32'(resp_valid), 32'(m_full));
            if (!found) begin
                check_val("alu_idle_op", 32'(alu_op), 32'(ADD));
                check_val("alu_idle_a", alu_a, 32'd0);
                check_val("alu_idle_b", alu_b, 32'd0);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_g[i]) begin
                    check_val("alu_op", 32'(alu_op), 32'(req_op[i]));
                    check_val("alu_a", alu_a, req_a[i]);
                    check_val("alu_b", alu_b, req_b[i]);
                    check_val("alu_mod", 32'(alu_mod), 32'(req_mod[i]));
                end
                if (m_full[i]) begin
                    check_val("sb_depth", 32'(sbq[i].size()), 32'd1);
                    if (sbq[i].size() > 0)
                        check_val("resp_data", resp_data[i], sbq[i][0]);
                end
            end
            if (reset_i) begin
                m_full = '0;
                m_last = NUM_REQ - 1;
                for (int i = 0; i < NUM_REQ; i++) sbq[i].delete();
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (m_full[i] && resp_ready[i]) begin
                        if (sbq[i].size() > 0) void'(sbq[i].pop_front());
                        m_full[i] = 1'b0;
                    end
                    if (exp_g[i]) begin
                        sbq[i].push_back(alu_fn(req_op[i], req_a[i], req_b[i], req_mod[i]));
                        m_full[i] = 1'b1;
                    end
                end
                if (found) m_last = gidx;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        reset_i    = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        req_op[0] = ADD; req_a[0] = 32'd5; req_b[0] = 32'd7; req_mod[0] = 1'b0;
        req_op[1] = ADD; req_a[1] = 32'd0; req_b[1] = 32'd0; req_mod[1] = 1'b0;

        // Reset held two cycles with all requests valid
        step();
        mon_en = 1'b1;
        sample();
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_data0", resp_data[0], 32'd0);
        check_val("rst_resp_data1", resp_data[1], 32'd0);
        step();
        reset_i = 1'b0;
        sample();
        check_val("first_grant", 32'(req_ready), 32'b01);
        check_val("add_alu_a", alu_a, 32'd5);
        check_val("add_alu_b", alu_b, 32'd7);

        // ADD 5+7 result one cycle later
        step();
        req_valid = 2'b00;
        sample();
        check_val("add_resp_valid0", 32'(resp_valid[0]), 32'd1);
        check_val("add_resp_data0", resp_data[0], 32'd12);

        // Alternating grants: XOR on req0, signed compare on req1
        step();
        req_valid = 2'b11;
        req_op[0] = XOR; req_a[0] = 32'h0000_00F0; req_b[0] = 32'h0000_000F;
        req_op[1] = SLT; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
        for (int n = 0; n < 8; n++) begin
            sample();
            check_val("rr_alt", 32'(req_ready), (n % 2 == 0) ? 32'b10 : 32'b01);
            if (n > 0) begin
                if (n % 2 == 1) check_val("slt_res", resp_data[1], 32'd1);
                else            check_val("xor_res", resp_data[0], 32'h0000_00FF);
            end
            step();
        end
        req_valid = 2'b00;
        step();
        step();

        // Back-pressure on req1 blocks it; req0 gets every cycle
        req_valid = 2'b10;
        sample();
        check_val("bp_first", 32'(req_ready), 32'b10);
        step();
        resp_ready = 2'b01;
        req_valid  = 2'b11;
        req_op[0]  = ADD; req_b[0] = 32'd100;
        for (int n = 0; n < 5; n++) begin
            req_a[0] = 32'(n * 3);
            sample();
            check_val("bp_req0_only", 32'(req_ready), 32'b01);
            check_val("bp_hold_valid1", 32'(resp_valid[1]), 32'd1);
            check_val("bp_hold_data1", resp_data[1], 32'd1);
            step();
        end
        resp_ready = 2'b11;
        sample();
        check_val("bp_release", 32'(req_ready), 32'b10);
`ifdef ALU_ARB_STATS_EN
        check_val("stall_count", stall_count, 32'd5);
`endif
        step();
        req_valid = 2'b00;
        step();
        step();

        // Back-to-back on req0: drain and reload in the same cycle
        req_valid = 2'b01;
        req_op[0] = ADD; req_a[0] = 32'd1; req_b[0] = 32'd1; req_mod[0] = 1'b0;
        sample();
        check_val("b2b_grant_a", 32'(req_ready), 32'b01);
        step();
        req_op[0] = SR; req_a[0] = 32'h8000_0000; req_b[0] = 32'd4; req_mod[0] = 1'b1;
        sample();
        check_val("b2b_grant_b", 32'(req_ready), 32'b01);
        check_val("b2b_first_data", resp_data[0], 32'd2);
        step();
        req_valid = 2'b00;
        req_mod[0] = 1'b0;
        sample();
        check_val("b2b_valid", 32'(resp_valid[0]), 32'd1);
        check_val("sra_res", resp_data[0], 32'hF800_0000);
        step();
        step();

        // Reset while req1's result is in flight
        req_valid = 2'b10;
        req_op[1] = SUB; req_a[1] = 32'd9; req_b[1] = 32'd4;
        sample();
        check_val("pre_rst_grant1", 32'(req_ready), 32'b10);
        step();
        reset_i = 1'b1;
        sample();
        check_val("rst_no_grant", 32'(req_ready), 32'd0);
        step();
        reset_i   = 1'b0;
        req_valid = 2'b11;
        sample();
        check_val("post_rst_valid", 32'(resp_valid), 32'd0);
        check_val("post_rst_grant0", 32'(req_ready), 32'b01);
`ifdef ALU_ARB_STATS_EN
        check_val("post_rst_gcnt0", grant_count[0], 32'd0);
        check_val("post_rst_gcnt1", grant_count[1], 32'd0);
        check_val("post_rst_stall", stall_count, 32'd0);
`endif
        step();
        req_valid = 2'b00;
        step();
        step();
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
